// File: rtl/wb_write_arbiter_pkg.sv
// wb_write_arbiter_pkg: shared register-file widths and write-source encoding
package wb_write_arbiter_pkg;
  localparam int RegBus = 32;
  localparam int RegAddrBus = 5;
  localparam int RegNum = 32;
  localparam int LuFifoDepth = 2;
  localparam logic WriteEnable = 1'b1;
  localparam logic [RegBus-1:0] ZeroWord = '0;
  typedef enum logic [1:0] {SRC_IDLE, SRC_WB, SRC_FIFO, SRC_BYP} wr_src_e;
  function automatic logic lu_sourced(input wr_src_e s);
    return s == SRC_FIFO || s == SRC_BYP;
  endfunction
endpackage

// File: rtl/wb_lu_fifo.sv
// wb_lu_fifo: small synchronous FIFO holding long-unit results that lost arbitration
module wb_lu_fifo #(
  parameter int W = 37,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign head = mem[rp];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: merges pipeline writeback and long-unit results onto the RF write port
module wb_write_arbiter
  import wb_write_arbiter_pkg::*;
#(
  parameter int DATA_W = RegBus,
  parameter int ADDR_W = RegAddrBus,
  parameter int REG_NUM = RegNum,
  parameter int FIFO_DEPTH = LuFifoDepth
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_waddr,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic              lu_valid,
  output logic              lu_ready,
  input  logic [ADDR_W-1:0] lu_waddr,
  input  logic [DATA_W-1:0] lu_wdata,
  input  logic              iss_we,
  input  logic [ADDR_W-1:0] iss_addr,
  input  logic [ADDR_W-1:0] chk_addr1,
  input  logic [ADDR_W-1:0] chk_addr2,
  output logic              chk_busy1,
  output logic              chk_busy2,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              err_waw
);
  localparam int EW = ADDR_W + DATA_W;
  logic full, empty, wb_act, byp, push, pop, lu_wr;
  logic [EW-1:0] head;
  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_data;
  logic [REG_NUM-1:0] busy, set_m, clr_m;
  wr_src_e src;
  assign {h_addr, h_data} = head;
  assign lu_ready = !full;
  assign wb_act = wb_we && wb_waddr != '0;
  // Bypass consumes the result even for address 0, which is then simply dropped
  assign byp = !wb_act && empty && lu_valid;
  assign push = lu_valid && lu_ready && lu_waddr != '0 && !byp;
  assign pop = src == SRC_FIFO;
  always_comb
    src = !rst ? SRC_IDLE :
          wb_act ? SRC_WB :
          !empty ? SRC_FIFO :
          (byp && lu_waddr != '0) ? SRC_BYP : SRC_IDLE;
  assign rf_we = src != SRC_IDLE;
  assign rf_waddr = src == SRC_WB ? wb_waddr : src == SRC_FIFO ? h_addr : src == SRC_BYP ? lu_waddr : '0;
  assign rf_wdata = src == SRC_WB ? wb_wdata : src == SRC_FIFO ? h_data : src == SRC_BYP ? lu_wdata : '0;
  assign lu_wr = lu_sourced(src);
  always_comb begin
    set_m = (iss_we && iss_addr != '0) ? REG_NUM'(1) << iss_addr : '0;
    clr_m = lu_wr ? REG_NUM'(1) << rf_waddr : '0;
  end
  // Same-cycle long-unit commit is forwarded by the register file, so it is not a hazard
  assign chk_busy1 = rst && chk_addr1 != '0 && busy[chk_addr1] && !(lu_wr && rf_waddr == chk_addr1);
  assign chk_busy2 = rst && chk_addr2 != '0 && busy[chk_addr2] && !(lu_wr && rf_waddr == chk_addr2);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      busy <= '0;
      err_waw <= 1'b0;
    end else begin
      busy <= (busy & ~clr_m) | set_m;
      err_waw <= err_waw | (wb_act && busy[wb_waddr]);
    end
  wb_lu_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  ({lu_waddr, lu_wdata}),
    .head (head),
    .full (full),
    .empty(empty)
  );
endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb_wb_write_arbiter: scoreboard bench for the register-file write arbiter
module tb_wb_write_arbiter;
  logic clk = 0, rst = 0;
  logic wb_we = 0, lu_valid = 0, iss_we = 0;
  logic [4:0] wb_waddr = 0, lu_waddr = 0, iss_addr = 0, chk_addr1 = 0, chk_addr2 = 0;
  logic [31:0] wb_wdata = 0, lu_wdata = 0;
  logic lu_ready, chk_busy1, chk_busy2, rf_we, err_waw;
  logic [4:0] rf_waddr;
  logic [31:0] rf_wdata;
  int errors = 0, checks = 0;
  logic [36:0] lu_q[$];
  logic acc;

  always #5 clk = ~clk;

  wb_write_arbiter dut (
    .clk(clk), .rst(rst), .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata),
    .iss_we(iss_we), .iss_addr(iss_addr), .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
    .chk_busy1(chk_busy1), .chk_busy2(chk_busy2), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .err_waw(err_waw)
  );

  // Pipeline writes must appear immediately; otherwise the oldest accepted long-unit result, else nothing
  always @(negedge clk) begin
    logic [36:0] e;
    #3;
    if (rst) begin
      checks++;
      if (wb_we && wb_waddr != 0) begin
        if (!(rf_we === 1'b1 && rf_waddr === wb_waddr && rf_wdata === wb_wdata)) begin
          errors++;
          $display("FAIL mon_wb: got we=%b a=%0d d=%h, want we=1 a=%0d d=%h", rf_we, rf_waddr, rf_wdata, wb_waddr, wb_wdata);
        end
      end else if (lu_q.size() > 0) begin
        e = lu_q.pop_front();
        if (!(rf_we === 1'b1 && rf_waddr === e[36:32] && rf_wdata === e[31:0])) begin
          errors++;
          $display("FAIL mon_lu: got we=%b a=%0d d=%h, want we=1 a=%0d d=%h", rf_we, rf_waddr, rf_wdata, e[36:32], e[31:0]);
        end
      end else if (rf_we !== 1'b0) begin
        errors++;
        $display("FAIL mon_idle: got we=%b a=%0d, want we=0", rf_we, rf_waddr);
      end
    end
  end

  task automatic cyc(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic lv, input logic [4:0] la, input logic [31:0] ld,
                     input logic iw, input logic [4:0] ia, output logic a);
    @(negedge clk);
    wb_we = we; wb_waddr = wa; wb_wdata = wd;
    lu_valid = lv; lu_waddr = la; lu_wdata = ld;
    iss_we = iw; iss_addr = ia;
    #2;
    a = lv && lu_ready;
    if (a && la != 0) lu_q.push_back({la, ld});
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, acc);
  endtask

  task automatic test_reset();
    chk_addr1 = 5'd1; chk_addr2 = 5'd2;
    #3;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rst_rf_we: got %b want 0", rf_we); end
    checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL rst_lu_ready: got %b want 1", lu_ready); end
    checks++; if ({chk_busy1, chk_busy2} !== 2'b00) begin errors++; $display("FAIL rst_chk_busy: got %b want 00", {chk_busy1, chk_busy2}); end
    checks++; if (err_waw !== 1'b0) begin errors++; $display("FAIL rst_err_waw: got %b want 0", err_waw); end
    @(negedge clk); rst = 1;
    idle();
    checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL idle_lu_ready: got %b want 1", lu_ready); end
  endtask

  task automatic test_bypass();
    cyc(0, 0, 0, 1, 5'd5, 32'hDEADBEEF, 0, 0, acc);
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      errors++; $display("FAIL bypass: got we=%b a=%0d d=%h want 1/5/deadbeef", rf_we, rf_waddr, rf_wdata); end
    idle();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL bypass_empty: got we=%b want 0", rf_we); end
  endtask

  task automatic test_back_to_back();
    logic [4:0] la [3];
    int idx = 0, c = 0;
    la[0] = 5'd7; la[1] = 5'd8; la[2] = 5'd9;
    while (c < 12 && !(c >= 3 && idx == 3 && lu_q.size() == 0)) begin
      cyc(c < 3, 5'd3, 32'h11, idx < 3, idx < 3 ? la[idx] : 5'd0, 32'hA000_0000 + idx, 0, 0, acc);
      if (c == 0) begin checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready0: got %b want 1", lu_ready); end end
      if (c == 2) begin checks++; if (lu_ready !== 1'b0) begin errors++; $display("FAIL b2b_full: got %b want 0", lu_ready); end end
      if (acc) idx++;
      c++;
    end
    checks++; if (idx != 3 || lu_q.size() != 0) begin
      errors++; $display("FAIL b2b_drain: sent %0d pending %0d, want 3 sent 0 pending", idx, lu_q.size()); end
  endtask

  task automatic test_scoreboard();
    chk_addr1 = 5'd9;
    cyc(0, 0, 0, 0, 0, 0, 1, 5'd9, acc);
    idle();
    checks++; if (chk_busy1 !== 1'b1) begin errors++; $display("FAIL sb_set: got %b want 1", chk_busy1); end
    cyc(0, 0, 0, 1, 5'd9, 32'h99, 0, 0, acc);
    checks++; if (chk_busy1 !== 1'b0 || rf_waddr !== 5'd9) begin
      errors++; $display("FAIL sb_fwd: got busy=%b a=%0d want 0/9", chk_busy1, rf_waddr); end
    idle();
    checks++; if (chk_busy1 !== 1'b0) begin errors++; $display("FAIL sb_clr: got %b want 0", chk_busy1); end
    cyc(0, 0, 0, 0, 0, 0, 1, 5'd9, acc);
    cyc(0, 0, 0, 1, 5'd9, 32'h98, 1, 5'd9, acc);
    idle();
    checks++; if (chk_busy1 !== 1'b1) begin errors++; $display("FAIL sb_set_wins: got %b want 1", chk_busy1); end
    cyc(0, 0, 0, 1, 5'd9, 32'h97, 0, 0, acc);
    idle();
    checks++; if (chk_busy1 !== 1'b0) begin errors++; $display("FAIL sb_clr2: got %b want 0", chk_busy1); end
    chk_addr1 = 5'd0;
    cyc(0, 0, 0, 0, 0, 0, 1, 5'd0, acc);
    idle();
    checks++; if (chk_busy1 !== 1'b0) begin errors++; $display("FAIL sb_zero: got %b want 0", chk_busy1); end
  endtask

  task automatic test_waw();
    chk_addr2 = 5'd4;
    cyc(0, 0, 0, 0, 0, 0, 1, 5'd4, acc);
    cyc(1, 5'd4, 32'h44, 0, 0, 0, 0, 0, acc);
    checks++; if (err_waw !== 1'b0) begin errors++; $display("FAIL waw_pre: got %b want 0", err_waw); end
    idle();
    checks++; if (err_waw !== 1'b1) begin errors++; $display("FAIL waw_set: got %b want 1", err_waw); end
    checks++; if (chk_busy2 !== 1'b1) begin errors++; $display("FAIL waw_busy_kept: got %b want 1", chk_busy2); end
    cyc(0, 0, 0, 1, 5'd4, 32'h4444, 0, 0, acc);
    idle();
    checks++; if (err_waw !== 1'b1 || chk_busy2 !== 1'b0) begin
      errors++; $display("FAIL waw_sticky: got err=%b busy=%b want 1/0", err_waw, chk_busy2); end
  endtask

  task automatic test_addr0_and_reset();
    cyc(1, 5'd3, 32'h33, 1, 5'd6, 32'h66, 0, 0, acc);
    cyc(1, 5'd3, 32'h34, 1, 5'd0, 32'hBAD, 0, 0, acc);
    checks++; if (acc !== 1'b1) begin errors++; $display("FAIL a0_accept: got %b want 1", acc); end
    cyc(1, 5'd3, 32'h35, 0, 0, 0, 0, 0, acc);
    checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL a0_count: ready got %b want 1", lu_ready); end
    cyc(1, 5'd0, 32'h36, 0, 0, 0, 0, 0, acc);
    checks++; if ({rf_we, rf_waddr} !== {1'b1, 5'd6}) begin
      errors++; $display("FAIL a0_wb_zero: got we=%b a=%0d want 1/6", rf_we, rf_waddr); end
    idle();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL a0_no_write: got %b want 0", rf_we); end
    chk_addr1 = 5'd12;
    cyc(1, 5'd3, 32'h37, 1, 5'd10, 32'hA, 1, 5'd12, acc);
    cyc(1, 5'd3, 32'h38, 1, 5'd11, 32'hB, 0, 0, acc);
    cyc(1, 5'd3, 32'h39, 0, 0, 0, 0, 0, acc);
    checks++; if ({lu_ready, chk_busy1, err_waw} !== 3'b011) begin
      errors++; $display("FAIL pre_rst: got ready/busy/err=%b want 011", {lu_ready, chk_busy1, err_waw}); end
    @(negedge clk);
    #1 rst = 0;
    lu_q.delete();
    wb_we = 0; lu_valid = 0; iss_we = 0;
    #1;
    checks++; if ({rf_we, lu_ready, chk_busy1, err_waw} !== 4'b0100) begin
      errors++; $display("FAIL mid_rst: got we/ready/busy/err=%b want 0100", {rf_we, lu_ready, chk_busy1, err_waw}); end
    @(negedge clk); rst = 1;
    idle();
    checks++; if ({rf_we, lu_ready, chk_busy1} !== 3'b010) begin
      errors++; $display("FAIL post_rst: got we/ready/busy=%b want 010", {rf_we, lu_ready, chk_busy1}); end
    idle();
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_back_to_back();
    test_scoreboard();
    test_waw();
    test_addr0_and_reset();
    checks++; if (lu_q.size() != 0) begin errors++; $display("FAIL final_pending: got %0d want 0", lu_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
